// File: rtl/quad_pkg.sv
// Shared definitions for the multi-channel quadrature decoder: register offsets,
// STATUS bit positions and the step classification used by each channel.
package quad_pkg;

    localparam logic [1:0] REG_COUNT       = 2'd0;
    localparam logic [1:0] REG_STATUS      = 2'd1;
    localparam logic [1:0] REG_INDEX_LATCH = 2'd2;
    localparam logic [1:0] REG_PRESCALER   = 2'd3;

    localparam int STATUS_ERR_BIT = 0;
    localparam int STATUS_IDX_BIT = 1;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2,
        STEP_ERR  = 2'd3
    } stepT;

    // Forward order of {A,B} is 00 -> 10 -> 11 -> 01 -> 00; a two-bit jump is illegal.
    function automatic stepT decodeStep(input logic [1:0] oldState, input logic [1:0] newState);
        stepT result;
        case ({oldState, newState})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: result = STEP_INC;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: result = STEP_DEC;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: result = STEP_ERR;
            default:                            result = STEP_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: pin synchroniser, 2-tick debounce, step decode, position
// counter and sticky status. Index support is compiled in with QUAD_INDEX_EN.
module quad_channel
    import quad_pkg::*;
#(
    parameter int pCOUNT_BITS = 16
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic                   iTICK,
    input  logic                   iENC_A,
    input  logic                   iENC_B,
`ifdef QUAD_INDEX_EN
    input  logic                   iENC_IDX,
`endif
    input  logic                   iCOUNT_WR,
    input  logic [pCOUNT_BITS-1:0] iCOUNT_DATA,
    input  logic [1:0]             iSTATUS_CLR,
    output logic [pCOUNT_BITS-1:0] oCOUNT,
    output logic [1:0]             oSTATUS,
    output logic [pCOUNT_BITS-1:0] oINDEX_LATCH
);

    logic [1:0]             rSync1;
    logic [1:0]             rSync2;
    logic [1:0]             rSamp;
    logic [1:0]             rAcc;
    logic [1:0]             rPrev;
    logic                   rSampValid;
    logic                   rAccStb;
    logic                   rPrimed;
    logic                   rErr;
    logic [pCOUNT_BITS-1:0] rCount;
    logic [pCOUNT_BITS-1:0] wCountNext;
    logic                   wIdxRise;
    logic                   wIdxSeen;
    stepT                   wStep;

    // Two-flop synchroniser on the A/B pins.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rSync1 <= 2'b00;
            rSync2 <= 2'b00;
        end else begin
            rSync1 <= {iENC_A, iENC_B};
            rSync2 <= rSync1;
        end
    end

    // Debounce: accept only when two consecutive tick samples agree; the
    // first sample after reset is never a valid comparison partner.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rSamp      <= 2'b00;
            rSampValid <= 1'b0;
            rAcc       <= 2'b00;
            rAccStb    <= 1'b0;
        end else begin
            rAccStb <= iTICK && rSampValid && (rSync2 == rSamp);
            if (iTICK) begin
                rSamp      <= rSync2;
                rSampValid <= 1'b1;
                if (rSampValid && (rSync2 == rSamp)) begin
                    rAcc <= rSync2;
                end
            end
        end
    end

`ifdef QUAD_INDEX_EN
    logic [1:0]             rIdxSync;
    logic                   rIdxSamp;
    logic                   rIdxAcc;
    logic                   rIdxPrev;
    logic                   rIdxSeen;
    logic [pCOUNT_BITS-1:0] rIdxLatch;

    // Index pin path mirrors A/B: synchronise, debounce, then edge-detect.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rIdxSync <= 2'b00;
            rIdxSamp <= 1'b0;
            rIdxAcc  <= 1'b0;
            rIdxPrev <= 1'b0;
        end else begin
            rIdxSync <= {rIdxSync[0], iENC_IDX};
            rIdxPrev <= rIdxAcc;
            if (iTICK) begin
                rIdxSamp <= rIdxSync[1];
                if (rSampValid && (rIdxSync[1] == rIdxSamp)) begin
                    rIdxAcc <= rIdxSync[1];
                end
            end
        end
    end

    assign wIdxRise = rIdxAcc & ~rIdxPrev;

    // Index latch and sticky IDX_SEEN; a fresh index beats a same-cycle clear.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rIdxLatch <= '0;
            rIdxSeen  <= 1'b0;
        end else begin
            if (wIdxRise) begin
                rIdxLatch <= rCount;
            end
            if (wIdxRise) begin
                rIdxSeen <= 1'b1;
            end else if (iSTATUS_CLR[STATUS_IDX_BIT]) begin
                rIdxSeen <= 1'b0;
            end
        end
    end

    assign wIdxSeen     = rIdxSeen;
    assign oINDEX_LATCH = rIdxLatch;
`else
    logic unusedIdxClr;
    assign unusedIdxClr = iSTATUS_CLR[STATUS_IDX_BIT];
    assign wIdxRise     = 1'b0;
    assign wIdxSeen     = 1'b0;
    assign oINDEX_LATCH = '0;
`endif

    // Classify the accepted-state change; nothing is counted until primed.
    always_comb begin
        wStep = STEP_NONE;
        if (rAccStb && rPrimed) begin
            wStep = decodeStep(rPrev, rAcc);
        end else begin
            wStep = STEP_NONE;
        end
    end

    // Counter priority: bus write, then index clear, then decoded step.
    always_comb begin
        wCountNext = rCount;
        if (iCOUNT_WR) begin
            wCountNext = iCOUNT_DATA;
        end else if (wIdxRise) begin
            wCountNext = '0;
        end else begin
            case (wStep)
                STEP_INC: wCountNext = rCount + pCOUNT_BITS'(1);
                STEP_DEC: wCountNext = rCount - pCOUNT_BITS'(1);
                default:  wCountNext = rCount;
            endcase
        end
    end

    // Counter, previous-state tracking and sticky ERR.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rCount  <= '0;
            rPrev   <= 2'b00;
            rPrimed <= 1'b0;
            rErr    <= 1'b0;
        end else begin
            rCount <= wCountNext;
            if (rAccStb) begin
                rPrev   <= rAcc;
                rPrimed <= 1'b1;
            end
            if (wStep == STEP_ERR) begin
                rErr <= 1'b1;
            end else if (iSTATUS_CLR[STATUS_ERR_BIT]) begin
                rErr <= 1'b0;
            end
        end
    end

    assign oCOUNT                  = rCount;
    assign oSTATUS[STATUS_ERR_BIT] = rErr;
    assign oSTATUS[STATUS_IDX_BIT] = wIdxSeen;

endmodule

// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: shared sample prescaler, register port with
// one-cycle read latency and error interrupt. Index support via QUAD_INDEX_EN.
module quad_decoder_multi
    import quad_pkg::*;
#(
    parameter int pCHANNELS   = 4,
    parameter int pCOUNT_BITS = 16,
    parameter int pPRESC_BITS = 8,
    parameter int pADDR_BITS  = 6
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic [pCHANNELS-1:0]  iENC_A,
    input  logic [pCHANNELS-1:0]  iENC_B,
`ifdef QUAD_INDEX_EN
    input  logic [pCHANNELS-1:0]  iENC_IDX,
`endif
    input  logic [pADDR_BITS-1:0] iADDRESS,
    input  logic                  iREAD,
    input  logic                  iWRITE,
    input  logic [31:0]           iWRITE_DATA,
    output logic [31:0]           oREAD_DATA,
    output logic                  oREAD_DATAVALID,
    output logic                  oIRQ
);

    localparam int CH_W = pADDR_BITS - 2;

    logic [pPRESC_BITS-1:0] rDiv;
    logic [pPRESC_BITS-1:0] rPrescCnt;
    logic                   wTick;
    logic                   wDivWr;
    logic [1:0]             wRegSel;
    logic [CH_W-1:0]        wChSel;
    logic [pCOUNT_BITS-1:0] wCount    [pCHANNELS];
    logic [pCOUNT_BITS-1:0] wIdxLatch [pCHANNELS];
    logic [1:0]             wStatus   [pCHANNELS];
    logic [pCHANNELS-1:0]   wErrVec;
    logic [31:0]            wRdMux;
    logic [31:0]            rReadData;
    logic                   rReadValid;
    logic                   rIrq;
    logic                   unusedWriteData;

    function automatic logic [31:0] signExt(input logic [pCOUNT_BITS-1:0] v);
        return 32'(signed'(v));
    endfunction

    assign wRegSel         = iADDRESS[1:0];
    assign wChSel          = iADDRESS[pADDR_BITS-1:2];
    assign wTick           = (rPrescCnt == rDiv);
    assign wDivWr          = iWRITE && (wChSel == {CH_W{1'b0}}) && (wRegSel == REG_PRESCALER);
    assign unusedWriteData = ^iWRITE_DATA;

    // Sample prescaler: counts 0..DIV, ticks on DIV; a DIV write restarts it.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rDiv      <= '0;
            rPrescCnt <= '0;
        end else if (wDivWr) begin
            rDiv      <= iWRITE_DATA[pPRESC_BITS-1:0];
            rPrescCnt <= '0;
        end else if (wTick) begin
            rPrescCnt <= '0;
        end else begin
            rPrescCnt <= rPrescCnt + pPRESC_BITS'(1);
        end
    end

    for (genvar g = 0; g < pCHANNELS; g++) begin : gCh
        logic wSel;
        assign wSel = (wChSel == CH_W'(g));

        quad_channel #(
            .pCOUNT_BITS (pCOUNT_BITS)
        ) uChannel (
            .iCLK         (iCLK),
            .iRESET       (iRESET),
            .iTICK        (wTick),
            .iENC_A       (iENC_A[g]),
            .iENC_B       (iENC_B[g]),
`ifdef QUAD_INDEX_EN
            .iENC_IDX     (iENC_IDX[g]),
`endif
            .iCOUNT_WR    (iWRITE && wSel && (wRegSel == REG_COUNT)),
            .iCOUNT_DATA  (iWRITE_DATA[pCOUNT_BITS-1:0]),
            .iSTATUS_CLR  ((iWRITE && wSel && (wRegSel == REG_STATUS)) ? iWRITE_DATA[1:0] : 2'b00),
            .oCOUNT       (wCount[g]),
            .oSTATUS      (wStatus[g]),
            .oINDEX_LATCH (wIdxLatch[g])
        );

        assign wErrVec[g] = wStatus[g][STATUS_ERR_BIT];
    end

    // Read mux; channel numbers beyond pCHANNELS match nothing and read 0.
    always_comb begin
        wRdMux = 32'd0;
        for (int c = 0; c < pCHANNELS; c++) begin
            if (wChSel == CH_W'(c)) begin
                case (wRegSel)
                    REG_COUNT:       wRdMux = signExt(wCount[c]);
                    REG_STATUS:      wRdMux = {30'd0, wStatus[c]};
                    REG_INDEX_LATCH: wRdMux = signExt(wIdxLatch[c]);
                    REG_PRESCALER:   wRdMux = (c == 0) ? 32'(rDiv) : 32'd0;
                    default:         wRdMux = 32'd0;
                endcase
            end else begin
                wRdMux = wRdMux;
            end
        end
    end

    // Registered read port and interrupt.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rReadData  <= 32'd0;
            rReadValid <= 1'b0;
            rIrq       <= 1'b0;
        end else begin
            rReadValid <= iREAD;
            rIrq       <= |wErrVec;
            if (iREAD) begin
                rReadData <= wRdMux;
            end
        end
    end

    assign oREAD_DATA      = rReadData;
    assign oREAD_DATAVALID = rReadValid;
    assign oIRQ            = rIrq;

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Directed bench for quad_decoder_multi; register reads are scoreboarded and
// checked when oREAD_DATAVALID pulses. Index test runs with QUAD_INDEX_EN.
module tb_quad_decoder_multi;

    localparam int CH = 4;
    localparam int CB = 16;
    localparam int PB = 8;
    localparam int AB = 6;

    logic          iCLK = 1'b0;
    logic          iRESET;
    logic [CH-1:0] encA;
    logic [CH-1:0] encB;
`ifdef QUAD_INDEX_EN
    logic [CH-1:0] encIdx;
`endif
    logic [AB-1:0] iADDRESS;
    logic          iREAD;
    logic          iWRITE;
    logic [31:0]   iWRITE_DATA;
    logic [31:0]   oREAD_DATA;
    logic          oREAD_DATAVALID;
    logic          oIRQ;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];

    always #5 iCLK = ~iCLK;

    quad_decoder_multi #(
        .pCHANNELS   (CH),
        .pCOUNT_BITS (CB),
        .pPRESC_BITS (PB),
        .pADDR_BITS  (AB)
    ) dut (
        .iCLK            (iCLK),
        .iRESET          (iRESET),
        .iENC_A          (encA),
        .iENC_B          (encB),
`ifdef QUAD_INDEX_EN
        .iENC_IDX        (encIdx),
`endif
        .iADDRESS        (iADDRESS),
        .iREAD           (iREAD),
        .iWRITE          (iWRITE),
        .iWRITE_DATA     (iWRITE_DATA),
        .oREAD_DATA      (oREAD_DATA),
        .oREAD_DATAVALID (oREAD_DATAVALID),
        .oIRQ            (oIRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [AB-1:0] adr(input int ch, input int r);
        return AB'(ch * 4 + r);
    endfunction

    // Scoreboard consumer: every valid pulse pops one expected read.
    always @(negedge iCLK) begin
        if (oREAD_DATAVALID) begin
            testsRun++;
            assert (expQ.size() != 0) else begin
                testsFailed++;
                $error("FAIL spurious_valid: observed valid with 0 pending reads, expected none");
            end
            if (expQ.size() != 0) begin
                check(tagQ.pop_front(), oREAD_DATA, expQ.pop_front());
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] exp, input string tag);
        @(negedge iCLK);
        iADDRESS = adr(ch, r);
        iREAD    = 1'b1;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(negedge iCLK);
        iREAD = 1'b0;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] data);
        @(negedge iCLK);
        iADDRESS    = adr(ch, r);
        iWRITE_DATA = data;
        iWRITE      = 1'b1;
        @(negedge iCLK);
        iWRITE = 1'b0;
    endtask

    task automatic setPins(input int ch, input logic a, input logic b, input int hold);
        @(negedge iCLK);
        encA[ch] = a;
        encB[ch] = b;
        clks(hold);
    endtask

    initial begin
        iRESET      = 1'b1;
        encA        = '0;
        encB        = '0;
`ifdef QUAD_INDEX_EN
        encIdx      = '0;
`endif
        iADDRESS    = '0;
        iREAD       = 1'b0;
        iWRITE      = 1'b0;
        iWRITE_DATA = 32'd0;
        clks(3);
        check("rst_valid", 32'(oREAD_DATAVALID), 32'd0);
        check("rst_irq", 32'(oIRQ), 32'd0);
        check("rst_rdata", oREAD_DATA, 32'd0);
        iRESET = 1'b0;
        clks(6);

        rd(0, 0, 32'd0, "rst_count");
        rd(0, 1, 32'd0, "rst_status");
        rd(0, 3, 32'd0, "rst_div");

        // Forward cycle on ch0.
        setPins(0, 1'b1, 1'b0, 4);
        setPins(0, 1'b1, 1'b1, 4);
        setPins(0, 1'b0, 1'b1, 4);
        setPins(0, 1'b0, 1'b0, 4);
        clks(6);
        rd(0, 0, 32'd4, "fwd_count");
        rd(0, 1, 32'd0, "fwd_status");
        check("fwd_irq", 32'(oIRQ), 32'd0);

        // Five reverse steps from zero, then the signed 16-bit boundaries.
        wr(0, 0, 32'd0);
        setPins(0, 1'b0, 1'b1, 4);
        setPins(0, 1'b1, 1'b1, 4);
        setPins(0, 1'b1, 1'b0, 4);
        setPins(0, 1'b0, 1'b0, 4);
        setPins(0, 1'b0, 1'b1, 4);
        clks(6);
        rd(0, 0, 32'hFFFF_FFFB, "rev_count");
        wr(0, 0, 32'h0000_7FFF);
        setPins(0, 1'b0, 1'b0, 6);
        rd(0, 0, 32'hFFFF_8000, "wrap_7fff_up");
        setPins(0, 1'b0, 1'b1, 6);
        rd(0, 0, 32'h0000_7FFF, "wrap_8000_down");
        wr(0, 0, 32'h0000_FFFF);
        setPins(0, 1'b0, 1'b0, 6);
        rd(0, 0, 32'd0, "wrap_ffff_up");

        // Illegal jump on ch1, then W1C and the interrupt drop timing.
        setPins(1, 1'b1, 1'b1, 10);
        rd(1, 1, 32'd1, "ch1_err");
        rd(1, 0, 32'd0, "ch1_count");
        check("ch1_irq_set", 32'(oIRQ), 32'd1);
        wr(1, 1, 32'd1);
        check("irq_hold_after_w1c", 32'(oIRQ), 32'd1);
        @(negedge iCLK);
        check("irq_drop", 32'(oIRQ), 32'd0);
        rd(1, 1, 32'd0, "ch1_err_clr");

        // Prescaler DIV=3: a one-clock glitch is filtered, a held change counts.
        wr(0, 3, 32'd3);
        rd(0, 3, 32'd3, "div_readback");
        @(negedge iCLK);
        encA[0] = 1'b1;
        @(negedge iCLK);
        encA[0] = 1'b0;
        clks(20);
        rd(0, 0, 32'd0, "glitch_filtered");
        setPins(0, 1'b1, 1'b0, 8);
        clks(14);
        rd(0, 0, 32'd1, "div3_step");
        setPins(0, 1'b0, 1'b0, 8);
        clks(14);
        wr(0, 3, 32'd0);
        clks(4);
        rd(0, 0, 32'd0, "div3_back");

        // COUNT write lands on the same edge as a decoded step.
        @(negedge iCLK);
        encA[0] = 1'b1;
        clks(4);
        iADDRESS    = adr(0, 0);
        iWRITE_DATA = 32'h0000_1234;
        iWRITE      = 1'b1;
        @(negedge iCLK);
        iWRITE = 1'b0;
        clks(6);
        rd(0, 0, 32'h0000_1234, "write_beats_step");

        // Read and write in one cycle returns the old value.
        @(negedge iCLK);
        iADDRESS    = adr(2, 0);
        iWRITE_DATA = 32'h0000_0055;
        iREAD       = 1'b1;
        iWRITE      = 1'b1;
        expQ.push_back(32'd0);
        tagQ.push_back("rw_same_cycle_old");
        @(negedge iCLK);
        iREAD  = 1'b0;
        iWRITE = 1'b0;
        rd(2, 0, 32'h0000_0055, "rw_same_cycle_new");
        wr(3, 3, 32'h0000_00AA);
        rd(3, 3, 32'd0, "ch3_reg3_zero");
        rd(0, 3, 32'd0, "div_untouched");
        rd(6, 0, 32'd0, "ch_out_of_range");

`ifdef QUAD_INDEX_EN
        wr(0, 0, 32'd77);
        @(negedge iCLK);
        encIdx[0] = 1'b1;
        clks(8);
        encIdx[0] = 1'b0;
        clks(8);
        rd(0, 2, 32'd77, "idx_latch");
        rd(0, 0, 32'd0, "idx_count_clr");
        rd(0, 1, 32'd2, "idx_seen");
`else
        rd(0, 2, 32'd0, "idx_latch_absent");
        rd(0, 1, 32'd0, "idx_seen_absent");
`endif

        clks(3);
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
